// File: rtl/rr_sched_pkg.sv
// Shared width helpers, consumer index type and reset-pivot function for the
// bank/port round-robin arbiter.
package rr_sched_pkg;

    localparam int DEF_NCONSUMERS = 8;

    // Index width for a power-of-two population.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Port index width; at least one bit even for a single-port bank.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_w(DEF_NCONSUMERS)-1:0] cons_idx_t;

    // Reset pivot for kernel k = b*nports + p: ports of one bank start spread
    // evenly across the consumer ring, banks are staggered by one.
    function automatic int reset_pivot(input int k, input int nports, input int ncons);
        int b;
        int p;
        b = k / nports;
        p = k % nports;
        return (b + p * (ncons / nports)) % ncons;
    endfunction

endpackage

// File: rtl/rr_bank_port_arbiter_if.sv
// Request/grant bundle between the consumer fabric and the arbiter.
// master = consumer side, slave = arbiter side.
interface rr_bank_port_arbiter_if
    import rr_sched_pkg::*;
#(
    parameter int NCONSUMERS = 8,
    parameter int NBANKS     = 4,
    parameter int NPORTS     = 2
);
    localparam int CONS_W = idx_w(NCONSUMERS);
    localparam int BANK_W = idx_w(NBANKS);
    localparam int PORT_W = port_w(NPORTS);

    logic [NCONSUMERS-1:0]               req;
    logic [NCONSUMERS*BANK_W-1:0]        req_bank;
    logic [NCONSUMERS-1:0]               gnt;
    logic [NCONSUMERS*PORT_W-1:0]        gnt_port;
    logic [NBANKS*NPORTS-1:0]            port_valid;
    logic [NBANKS*NPORTS*CONS_W-1:0]     port_sel;

    modport master (
        output req, req_bank,
        input  gnt, gnt_port, port_valid, port_sel
    );

    modport slave (
        input  req, req_bank,
        output gnt, gnt_port, port_valid, port_sel
    );

endinterface

// File: rtl/rr_port_pick.sv
// One scheduling kernel: first eligible consumer at or after the pivot,
// wrapping around the ring. Ring size must be a power of two.
module rr_port_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] pivot,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Scan from the far end so the last hit written is the one nearest the pivot.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = pivot + W'(off);
            if (elig[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bank_port_arbiter.sv
// Round-robin arbiter sharing NBANKS x NPORTS bank ports among NCONSUMERS.
// Optional build macro RR_STARVATION_GUARD_EN adds per-consumer age counters;
// aged consumers are placed on the lowest free ports ahead of the pivot scan.
module rr_bank_port_arbiter
    import rr_sched_pkg::*;
#(
    parameter int NCONSUMERS = 8,
    parameter int NBANKS     = 4,
    parameter int NPORTS     = 2,
    parameter int MAX_WAIT   = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    rr_bank_port_arbiter_if.slave bus
);

    localparam int CONS_W = idx_w(NCONSUMERS);
    localparam int BANK_W = idx_w(NBANKS);
    localparam int PORT_W = port_w(NPORTS);
    localparam int NK     = NBANKS * NPORTS;
    localparam bit PARAMS_OK = (MAX_WAIT >= 1) && (NBANKS >= 2) && (NPORTS >= 1)
                               && ((NCONSUMERS % NPORTS) == 0);

    logic [CONS_W-1:0]             rr_pivots [NK];
    logic [BANK_W-1:0]             rb [NCONSUMERS];
    logic [NCONSUMERS-1:0]         gnt_q;
    logic [NCONSUMERS*PORT_W-1:0]  gnt_port_q;
    logic [NK-1:0]                 port_valid_q;
    logic [NK*CONS_W-1:0]          port_sel_q;
    logic [NK-1:0]                 kv;
    logic [CONS_W-1:0]             ks [NK];
    logic [NCONSUMERS-1:0]         nxt_gnt;
    logic [NCONSUMERS*PORT_W-1:0]  nxt_gnt_port;
    logic [NK*CONS_W-1:0]          nxt_sel;

    for (genvar i = 0; i < NCONSUMERS; i++) begin : g_rb
        assign rb[i] = bus.req_bank[i*BANK_W +: BANK_W];
    end

`ifdef RR_STARVATION_GUARD_EN
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    logic [AGE_W-1:0]      age [NCONSUMERS];
    logic [NCONSUMERS-1:0] urgent;

    // Saturating wait age per consumer; cleared on grant or idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCONSUMERS; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < NCONSUMERS; i++) begin
                if (!bus.req[i] || gnt_q[i]) age[i] <= '0;
                else if (age[i] < AGE_W'(MAX_WAIT)) age[i] <= age[i] + 1'b1;
            end
        end
    end

    // Consumers that have waited MAX_WAIT cycles jump the queue.
    always_comb begin
        urgent = '0;
        for (int i = 0; i < NCONSUMERS; i++) urgent[i] = (age[i] >= AGE_W'(MAX_WAIT));
    end
`endif

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [NCONSUMERS-1:0] elig;

        // Pending requests for this bank, masked while their grant is showing.
        always_comb begin
            elig = '0;
            for (int i = 0; i < NCONSUMERS; i++)
                elig[i] = bus.req[i] && (rb[i] == BANK_W'(b)) && !gnt_q[i];
        end

        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            localparam int K = b * NPORTS + p;
            logic [NCONSUMERS-1:0] mask_in, avail, mask_out;
            logic                  rr_v, k_v;
            logic [CONS_W-1:0]     rr_i, k_i;

            if (p == 0) begin : g_first
                assign mask_in = '0;
            end else begin : g_chain
                assign mask_in = g_port[p-1].mask_out;
            end

            assign avail = elig & ~mask_in;

            rr_port_pick #(.N(NCONSUMERS), .W(CONS_W)) u_rr (
                .elig  (avail),
                .pivot (rr_pivots[K]),
                .valid (rr_v),
                .idx   (rr_i)
            );

`ifdef RR_STARVATION_GUARD_EN
            logic              ug_v;
            logic [CONS_W-1:0] ug_i;

            rr_port_pick #(.N(NCONSUMERS), .W(CONS_W)) u_urg (
                .elig  (avail & urgent),
                .pivot ('0),
                .valid (ug_v),
                .idx   (ug_i)
            );

            assign k_v = ug_v | rr_v;
            assign k_i = ug_v ? ug_i : rr_i;
`else
            assign k_v = rr_v;
            assign k_i = rr_i;
`endif

            assign mask_out = mask_in | (k_v ? (NCONSUMERS'(1) << k_i) : '0);
            assign kv[K]    = k_v;
            assign ks[K]    = k_i;
        end
    end

    // Fold kernel picks into per-consumer grants and per-kernel selects.
    always_comb begin
        nxt_gnt      = '0;
        nxt_gnt_port = '0;
        nxt_sel      = '0;
        for (int k = 0; k < NK; k++) begin
            if (kv[k]) begin
                nxt_gnt[ks[k]]                          = 1'b1;
                nxt_gnt_port[ks[k]*PORT_W +: PORT_W]    = PORT_W'(k % NPORTS);
                nxt_sel[k*CONS_W +: CONS_W]             = ks[k];
            end
        end
    end

    // Register the selection; pivots rotate every cycle regardless of grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q        <= '0;
            gnt_port_q   <= '0;
            port_valid_q <= '0;
            port_sel_q   <= '0;
            for (int k = 0; k < NK; k++)
                rr_pivots[k] <= CONS_W'(reset_pivot(k, NPORTS, NCONSUMERS));
        end else begin
            gnt_q        <= nxt_gnt;
            gnt_port_q   <= nxt_gnt_port;
            port_valid_q <= kv;
            port_sel_q   <= nxt_sel;
            for (int k = 0; k < NK; k++)
                rr_pivots[k] <= rr_pivots[k] + 1'b1;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_port   = gnt_port_q;
    assign bus.port_valid = port_valid_q;
    assign bus.port_sel   = port_sel_q;

    a_params: assert property (@(posedge clk) PARAMS_OK);

    // A pending consumer must not retarget before its grant arrives.
    for (genvar i = 0; i < NCONSUMERS; i++) begin : g_chk
        a_bank_stable: assert property (@(posedge clk) disable iff (!reset_n)
            (bus.req[i] && !gnt_q[i]) |=> (!bus.req[i] || gnt_q[i] || $stable(rb[i])));
    end

endmodule

// File: tb/tb_rr_bank_port_arbiter.sv
// Directed bench for rr_bank_port_arbiter with default parameters 8/4/2/8.
module tb_rr_bank_port_arbiter;

    localparam int NC = 8;
    localparam int NB = 4;
    localparam int NP = 2;
    localparam int MW = 8;
    localparam int CW = 3;
    localparam int BW = 2;
    localparam int NK = NB * NP;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    rr_bank_port_arbiter_if #(.NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP)) bus ();

    rr_bank_port_arbiter #(.NCONSUMERS(NC), .NBANKS(NB), .NPORTS(NP), .MAX_WAIT(MW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Enter reset with all requests cleared.
    task automatic enter_reset();
        reset_n      = 1'b0;
        bus.req      = '0;
        bus.req_bank = '0;
        @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int exp_a [NK] = '{0, 4, 1, 5, 2, 6, 3, 7};
        int exp_b [NK] = '{2, 6, 3, 7, 4, 0, 5, 1};
        enter_reset();
        @(posedge clk); #1;
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (int'(dut.rr_pivots[k]) !== exp_a[k])
                $display("FAIL reset_pivot[%0d] got %0d want %0d", k, dut.rr_pivots[k], exp_a[k]);
            else n_pass++;
        end
        n_checks++;
        if ({bus.gnt, bus.gnt_port, bus.port_valid, bus.port_sel} !== '0)
            $display("FAIL reset_outputs gnt=%h gnt_port=%h valid=%h sel=%h want 0",
                     bus.gnt, bus.gnt_port, bus.port_valid, bus.port_sel);
        else n_pass++;
        release_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (int'(dut.rr_pivots[k]) !== exp_b[k])
                $display("FAIL pivot_after2[%0d] got %0d want %0d", k, dut.rr_pivots[k], exp_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (bus.gnt !== 8'h00) $display("FAIL idle_gnt got %h want 00", bus.gnt);
        else n_pass++;
    endtask

    task automatic test_all_bank0();
        logic [7:0]  eg [3] = '{8'h11, 8'h22, 8'h44};
        logic [7:0]  ep [3] = '{8'h10, 8'h20, 8'h40};
        logic [23:0] es [3] = '{24'h000020, 24'h000029, 24'h000032};
        enter_reset();
        bus.req = 8'hFF;
        release_reset();
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.gnt !== eg[e]) $display("FAIL bank0_gnt e%0d got %h want %h", e + 1, bus.gnt, eg[e]);
            else n_pass++;
            n_checks++;
            if (bus.gnt_port !== ep[e]) $display("FAIL bank0_port e%0d got %h want %h", e + 1, bus.gnt_port, ep[e]);
            else n_pass++;
            n_checks++;
            if (bus.port_valid !== 8'h03 || bus.port_sel !== es[e])
                $display("FAIL bank0_sel e%0d got valid=%h sel=%h want 03/%h", e + 1, bus.port_valid, bus.port_sel, es[e]);
            else n_pass++;
            bus.req = bus.req & ~bus.gnt;
        end
    endtask

    task automatic test_single_bank2();
        enter_reset();
        bus.req[3] = 1'b1;
        bus.req_bank[3*BW +: BW] = 2'd2;
        release_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h08 || bus.gnt_port !== 8'h00)
            $display("FAIL single_gnt got gnt=%h port=%h want 08/00", bus.gnt, bus.gnt_port);
        else n_pass++;
        n_checks++;
        if (bus.port_valid !== 8'h10 || bus.port_sel !== 24'h003000)
            $display("FAIL single_sel got valid=%h sel=%h want 10/003000", bus.port_valid, bus.port_sel);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.port_valid !== 8'h00 || bus.port_sel !== 24'h0)
            $display("FAIL single_masked got gnt=%h valid=%h sel=%h want 00/00/0", bus.gnt, bus.port_valid, bus.port_sel);
        else n_pass++;
        bus.req = '0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h00) $display("FAIL single_no_regrant got %h want 00", bus.gnt);
        else n_pass++;
    endtask

    task automatic test_four_banks();
        enter_reset();
        for (int j = 0; j < 4; j++) begin
            bus.req[2*j] = 1'b1;
            bus.req_bank[2*j*BW +: BW] = BW'(j);
        end
        release_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h55 || bus.gnt_port !== 8'h00)
            $display("FAIL four_gnt got gnt=%h port=%h want 55/00", bus.gnt, bus.gnt_port);
        else n_pass++;
        n_checks++;
        if (bus.port_valid !== 8'h55 || bus.port_sel !== 24'h184080)
            $display("FAIL four_sel got valid=%h sel=%h want 55/184080", bus.port_valid, bus.port_sel);
        else n_pass++;
        bus.req = '0;
    endtask

    task automatic test_wrap();
        enter_reset();
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        bus.req_bank[1*BW +: BW] = 2'd3;
        bus.req_bank[3*BW +: BW] = 2'd3;
        release_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h0A || bus.gnt_port !== 8'h02)
            $display("FAIL wrap_gnt got gnt=%h port=%h want 0A/02", bus.gnt, bus.gnt_port);
        else n_pass++;
        n_checks++;
        if (bus.port_valid !== 8'hC0 || bus.port_sel !== 24'h2C0000)
            $display("FAIL wrap_sel got valid=%h sel=%h want C0/2C0000", bus.port_valid, bus.port_sel);
        else n_pass++;
        bus.req = '0;
    endtask

    task automatic test_async_reset();
        int exp_a [NK] = '{0, 4, 1, 5, 2, 6, 3, 7};
        enter_reset();
        bus.req = 8'h0F;
        release_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h03) $display("FAIL areset_pre got %h want 03", bus.gnt);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.gnt !== 8'h00 || bus.port_valid !== 8'h00 || bus.port_sel !== 24'h0 || bus.gnt_port !== 8'h00)
            $display("FAIL areset_drop got gnt=%h valid=%h sel=%h want 0", bus.gnt, bus.port_valid, bus.port_sel);
        else n_pass++;
        for (int k = 0; k < NK; k++) begin
            n_checks++;
            if (int'(dut.rr_pivots[k]) !== exp_a[k])
                $display("FAIL areset_pivot[%0d] got %0d want %0d", k, dut.rr_pivots[k], exp_a[k]);
            else n_pass++;
        end
        bus.req = 8'h0C;
        release_reset();
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 8'h0C || bus.gnt_port !== 8'h08)
            $display("FAIL areset_rearb got gnt=%h port=%h want 0C/08", bus.gnt, bus.gnt_port);
        else n_pass++;
        bus.req = '0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] eg [3] = '{8'h22, 8'h44, 8'h88};
        int         seen7 = 0;
        enter_reset();
        bus.req = 8'hFF;
        for (int i = 0; i < NC; i++) bus.req_bank[i*BW +: BW] = 2'd1;
        release_reset();
        for (int e = 1; e <= MW + 1; e++) begin
            @(posedge clk); #1;
            if (e <= 3) begin
                n_checks++;
                if (bus.gnt !== eg[e-1]) $display("FAIL b2b_gnt e%0d got %h want %h", e, bus.gnt, eg[e-1]);
                else n_pass++;
            end
            if (bus.gnt[7] && seen7 == 0) begin
                seen7 = e;
                n_checks++;
                if (bus.gnt_port !== 8'h80) $display("FAIL b2b_port7 got %h want 80", bus.gnt_port);
                else n_pass++;
                bus.req[7] = 1'b0;
            end
        end
        n_checks++;
        if (seen7 !== 3) $display("FAIL b2b_c7_edge got %0d want 3", seen7);
        else n_pass++;
        bus.req = '0;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_bank = '0;
        test_reset();
        test_all_bank0();
        test_single_bank2();
        test_four_banks();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_bank_port_arbiter.md
Name: rr_bank_port_arbiter

Overview:
- Shares NBANKS memory banks, each with NPORTS ports, among NCONSUMERS requesters.
- One scheduling kernel per (bank, port) pair. Kernel index k = b*NPORTS + p.
- Each kernel holds a rotating round-robin pivot. Every cycle, each kernel grants at most one consumer that targets its bank.
- Sits between the consumer request fabric and the bank port muxes; drives both the consumer grants and the port select lines.

Parameters:
- NCONSUMERS, 8, number of requesters; power of two; divisible by NPORTS.
- NBANKS, 4, number of banks; power of two, ≥2.
- NPORTS, 2, ports per bank; ≥1.
- MAX_WAIT, 8, starvation threshold in cycles; used only with the optional feature; ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NCONSUMERS  per-consumer request, level.
- req_bank  in  NCONSUMERS*BANK_W  per-consumer target bank; slice i belongs to consumer i.
- gnt  out  NCONSUMERS  registered one-cycle grant pulse.
- gnt_port  out  NCONSUMERS*PORT_W  port index granted to consumer i; valid when gnt[i]=1.
- port_valid  out  NBANKS*NPORTS  kernel k drives a consumer this cycle.
- port_sel  out  NBANKS*NPORTS*CONS_W  consumer index selected by kernel k.

Behaviour:
- Widths: CONS_W = $clog2(NCONSUMERS), BANK_W = $clog2(NBANKS), PORT_W = max(1, $clog2(NPORTS)). All pivot arithmetic is modulo NCONSUMERS and wraps naturally at CONS_W bits.
- Reset (reset_n=0, asynchronous):
  - rr_pivots[k] = (b + p*(NCONSUMERS/NPORTS)) mod NCONSUMERS. With the defaults this gives 0,4,1,5,2,6,3,7.
  - gnt=0, gnt_port=0, port_valid=0, port_sel=0.
- Pivot update: on every rising edge with reset_n=1, each rr_pivots[k] increments by 1 modulo NCONSUMERS. This happens unconditionally, whether or not the kernel granted.
- Eligibility: consumer i is eligible for bank b when req[i]=1, req_bank[i]=b, and gnt[i]=0. Masking on gnt prevents a double grant while the consumer is still dropping req.
- Selection, combinational, per bank:
  - Ports are evaluated in order p = 0..NPORTS-1.
  - Kernel (b,p) scans consumers pivot, pivot+1, … with wrap, and picks the first eligible consumer not already taken by a lower port of the same bank.
  - If no consumer qualifies, the kernel is idle.
- Registration: the selection computed from current req and current pivots is registered at the next edge.
  - Latency is exactly 1 cycle from req sampled to gnt high.
  - gnt is a single-cycle pulse.
  - port_valid and port_sel are registered in the same cycle as gnt.
- Handshake:
  - A consumer holds req and req_bank stable until it sees gnt.
  - It may drop req, or issue a new request, in the cycle gnt is high; that request is ignored this cycle because of the mask.
  - Changing req_bank while pending is illegal. An implementation assertion flags it.
- Invariants:
  - A consumer is granted by at most one kernel per cycle.
  - Kernels of different banks are independent.
  - When port_valid[k]=0, port_sel[k] holds 0.
- Reset mid-operation: all grants are dropped immediately and pivots reload. Pending requests are re-arbitrated after reset_n rises; nothing is retained.

Optional Feature:
- Macro: RR_STARVATION_GUARD_EN.
- With the macro defined:
  - Each consumer has a saturating age counter of width $clog2(MAX_WAIT+1), reset to 0.
  - The counter increments each cycle while req=1 and the consumer was not granted, and clears on grant or when req=0.
  - Consumers with age ≥ MAX_WAIT are "urgent". For each bank, urgent eligible consumers are assigned first, lowest index first, in port order 0..NPORTS-1.
  - Remaining ports use normal pivot selection.
  - Pivots still increment unconditionally.
- Without the macro: no counters; pure pivot round-robin.

Decomposition:
- Package rr_sched_pkg:
  - localparam helpers for the CONS_W, BANK_W and PORT_W widths.
  - A function returning the reset pivot for kernel k.
  - A typedef for the consumer index.
- Sub-module rr_port_pick: one kernel's combinational wrap-around scan. Inputs are the eligibility vector and the pivot; outputs are valid and the index.
- The top level chains NPORTS instances per bank through an exclusion mask.

Test Plan (defaults 8/4/2, MAX_WAIT=8):
- Hold reset_n low for 2 cycles → pivots 0,4,1,5,2,6,3,7; all outputs 0. Release and wait 2 edges → pivots 2,6,3,7,4,0,5,1.
- Release reset_n; in the first cycle all 8 consumers request bank 0, and each consumer drops req on gnt → edge 1 grants consumers 0 (port 0) and 4 (port 1); edge 2 grants 1 and 5; edge 3 grants 2 and 6.
- Only consumer 3 requests bank 2 while bank-2 pivots are 2 and 6 → gnt[3]=1 with gnt_port=0; port_valid for kernel (2,1)=0; consumer never granted twice.
- Consumers 0,2,4,6 request banks 0,1,2,3 simultaneously → all four granted in the same cycle on independent banks, each via port 0 or 1 as pivots dictate; no cross-bank interference.
- Assert reset_n=0 asynchronously mid-cycle with grants pending → gnt and port_valid drop before the next edge; pivots reload to reset values.
- With RR_STARVATION_GUARD_EN defined, consumer 7 holds a request to bank 1 while consumers 0–6 repeatedly re-request bank 1 → consumer 7 is granted no later than MAX_WAIT+1 cycles after first request; without the macro, grant order follows pivots only.
